// File: rtl/spram_arbiter_pkg.sv
// rtl/spram_arbiter_pkg.sv - shared port indices and reset constant for spram_arbiter
package spram_arbiter_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // B as the previous winner lets A take the first contended cycle after reset
    localparam port_e LAST_GRANT_RESET = PORT_B;

endpackage

// File: rtl/spram_arbiter_grant.sv
// rtl/spram_arbiter_grant.sv - one-hot grant select; SPRAM_ARBITER_RR_EN picks round-robin over fixed A priority
module spram_arbiter_grant
    import spram_arbiter_pkg::*;
(
    input  logic  i_a_req,
    input  logic  i_b_req,
    input  port_e i_last_grant,
    output logic  o_grant_a,
    output logic  o_grant_b
);

`ifndef SPRAM_ARBITER_RR_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

    always_comb begin
        o_grant_a = 1'b0;
        o_grant_b = 1'b0;
        if (i_a_req && i_b_req) begin
`ifdef SPRAM_ARBITER_RR_EN
            if (i_last_grant == PORT_A) begin
                o_grant_b = 1'b1;
            end else begin
                o_grant_a = 1'b1;
            end
`else
            o_grant_a = 1'b1;
`endif
        end else begin
            o_grant_a = i_a_req;
            o_grant_b = i_b_req;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester arbiter sharing one single-port RAM (SPRAM_ARBITER_RR_EN selects round-robin)
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int address_width = 8,
    parameter int data_width    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [address_width-1:0] a_addr,
    input  logic [data_width-1:0]    a_wdata,
    output logic                     a_ack,
    output logic                     a_rvalid,
    output logic [data_width-1:0]    a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [address_width-1:0] b_addr,
    input  logic [data_width-1:0]    b_wdata,
    output logic                     b_ack,
    output logic                     b_rvalid,
    output logic [data_width-1:0]    b_rdata,
    output logic                     ram_enable,
    output logic [address_width-1:0] ram_address,
    output logic [data_width-1:0]    ram_data,
    output logic                     ram_wren,
    input  logic [data_width-1:0]    ram_q
);

    logic  w_grant_a;
    logic  w_grant_b;
    port_e r_last_grant;
    logic  r_a_rvalid;
    logic  r_b_rvalid;

    spram_arbiter_grant u_grant (
        .i_a_req      (a_req),
        .i_b_req      (b_req),
        .i_last_grant (r_last_grant),
        .o_grant_a    (w_grant_a),
        .o_grant_b    (w_grant_b)
    );

    assign a_ack      = w_grant_a;
    assign b_ack      = w_grant_b;
    assign ram_enable = w_grant_a | w_grant_b;

    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (w_grant_a) begin
            ram_address = a_addr;
            ram_data    = a_wdata;
            ram_wren    = a_we;
        end else if (w_grant_b) begin
            ram_address = b_addr;
            ram_data    = b_wdata;
            ram_wren    = b_we;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= LAST_GRANT_RESET;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
        end else begin
            if (ram_enable) begin
                r_last_grant <= w_grant_b ? PORT_B : PORT_A;
            end
            r_a_rvalid <= w_grant_a & ~a_we;
            r_b_rvalid <= w_grant_b & ~b_we;
        end
    end

    // RAM q is only meaningful the cycle after a read, so gate it per port
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rvalid ? ram_q : '0;
    assign b_rdata  = r_b_rvalid ? ram_q : '0;

endmodule
